alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue_pkg.sv | 21 ++
 rtl/alu_issue_if.sv | 32 +++
 rtl/alu_issue_reg_file.sv | 32 +++
 rtl/alu_issue.sv | 122 ++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage: state encoding, op classes and widths.
package alu_issue_pkg;

    localparam int unsigned DataWidth   = 8;
    localparam int unsigned InstrWidth  = 9;
    localparam int unsigned OpWidth     = 5;
    localparam int unsigned RegIdxWidth = 3;
    localparam int unsigned NumRegs     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        WB   = 2'b10
    } state_e;

    // Op class is op[4:2]
    localparam logic [2:0] CLS_ADD = 3'b000;
    localparam logic [2:0] CLS_CMP = 3'b001;
    localparam logic [2:0] CLS_SRL = 3'b111;

endpackage

// File: rtl/alu_issue_if.sv
// Instruction handshake plus the bus to and from the external combinational ALU.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic [InstrWidth-1:0] instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  flush;
    logic                  done;

    logic [OpWidth-1:0]    alu_cmd;
    logic [DataWidth-1:0]  alu_inA;
    logic [DataWidth-1:0]  alu_inB;
    logic                  alu_sc_i;
    logic [DataWidth-1:0]  alu_rslt;
    logic                  alu_sc_o;
    logic                  alu_zero;
    logic                  alu_pari;

    // Issue block side
    modport slave (
        input  instr, instr_valid, flush, alu_rslt, alu_sc_o, alu_zero, alu_pari,
        output instr_ready, done, alu_cmd, alu_inA, alu_inB, alu_sc_i
    );

    // Upstream / ALU side
    modport master (
        output instr, instr_valid, flush, alu_rslt, alu_sc_o, alu_zero, alu_pari,
        input  instr_ready, done, alu_cmd, alu_inA, alu_inB, alu_sc_i
    );

endinterface

// File: rtl/alu_issue_reg_file.sv
// 8x8 register file: single write port into R0 (accumulator), reads for rs and debug.
module alu_issue_reg_file
    import alu_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [DataWidth-1:0]   wdata,
    input  logic [RegIdxWidth-1:0] rs_addr,
    output logic [DataWidth-1:0]   rs_data,
    input  logic [RegIdxWidth-1:0] dbg_addr,
    output logic [DataWidth-1:0]   dbg_data,
    output logic [DataWidth-1:0]   r0_data
);

    logic [DataWidth-1:0] regs_q [NumRegs];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we) begin
            regs_q[0] <= wdata;
        end
    end

    assign rs_data  = regs_q[rs_addr];
    assign dbg_data = regs_q[dbg_addr];
    assign r0_data  = regs_q[0];

endmodule

// File: rtl/alu_issue.sv
// Three-state issue stage: accept an instruction, drive the external ALU, then write back R0
// and the architectural flags.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    alu_issue_if.slave             bus,
    output logic                   carry_f,
    output logic                   zero_f,
    output logic                   pari_f,
    output logic                   cmp_f,
    input  logic [RegIdxWidth-1:0] dbg_sel,
    output logic [DataWidth-1:0]   dbg_data
);

    state_e state_q, state_d;

    logic [OpWidth-1:0]     op_q;
    logic [RegIdxWidth-1:0] rs_q;
    logic                   cin_en_q;

    logic [DataWidth-1:0]   rslt_q;
    logic                   sc_q, zero_q, pari_q;

    logic carry_q, zflag_q, pflag_q, cmp_q;

    logic                 accept, capture, in_wb, is_cmp, upd_carry, r0_we;
    logic [2:0]           op_cls;
    logic [DataWidth-1:0] r0_data, rs_data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.instr_valid) state_d = EXEC;
            EXEC:    state_d = bus.flush ? IDLE : WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign accept    = (state_q == IDLE) && bus.instr_valid;
    assign capture   = (state_q == EXEC) && !bus.flush;
    assign in_wb     = (state_q == WB);
    assign op_cls    = op_q[4:2];
    assign is_cmp    = (op_cls == CLS_CMP);
    assign upd_carry = in_wb && ((op_cls == CLS_ADD) || (op_cls == CLS_SRL));
    assign r0_we     = in_wb && !is_cmp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            rs_q     <= '0;
            cin_en_q <= 1'b0;
        end else if (accept) begin
            op_q     <= bus.instr[8:4];
            rs_q     <= bus.instr[3:1];
            cin_en_q <= bus.instr[0];
        end
    end

    // A flushed EXEC never reaches WB, so the stale capture is never consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rslt_q <= '0;
            sc_q   <= 1'b0;
            zero_q <= 1'b0;
            pari_q <= 1'b0;
        end else if (capture) begin
            rslt_q <= bus.alu_rslt;
            sc_q   <= bus.alu_sc_o;
            zero_q <= bus.alu_zero;
            pari_q <= bus.alu_pari;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
            zflag_q <= 1'b0;
            pflag_q <= 1'b0;
            cmp_q   <= 1'b0;
        end else begin
            if (upd_carry) carry_q <= sc_q;
            if (in_wb) begin
                zflag_q <= zero_q;
                pflag_q <= pari_q;
                if (is_cmp) cmp_q <= (rslt_q == 8'h01);
            end
        end
    end

    alu_issue_reg_file reg_file (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (r0_we),
        .wdata    (rslt_q),
        .rs_addr  (rs_q),
        .rs_data  (rs_data),
        .dbg_addr (dbg_sel),
        .dbg_data (dbg_data),
        .r0_data  (r0_data)
    );

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.done        = in_wb;
    assign bus.alu_cmd     = op_q;
    assign bus.alu_inA     = r0_data;
    assign bus.alu_inB     = rs_data;
    assign bus.alu_sc_i    = carry_q & cin_en_q;

    assign carry_f = carry_q;
    assign zero_f  = zflag_q;
    assign pari_f  = pflag_q;
    assign cmp_f   = cmp_q;

endmodule
